// File: rtl/pipe_pkg.sv
// Shared definitions for the fetch stage: pcsource encodings, bubble word and fetch FSM states.
// The optional PIPE_FLUSH_EN macro is consumed by pipe_fetch, not by this package.
package pipe_pkg;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JR  = 2'b10;
  localparam logic [1:0] PC_J   = 2'b11;

  // sll $0,$0,0
  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    PEND = 1'b1
  } fetch_state_t;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/pipe_npc.sv
// Next-PC selection: 4:1 pcsource mux with the captured pending redirect taking priority.
// Purely combinational; all state lives in pipe_fetch.
module pipe_npc
  import pipe_pkg::*;
(
  input  logic [1:0]  pcsource,
  input  logic [31:0] pc4,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  input  logic [31:0] da,
  input  logic        pend,
  input  logic [31:0] pend_tgt,
  output logic [31:0] sel_tgt,
  output logic        redirect,
  output logic [31:0] npc
);

  always_comb begin
    sel_tgt = pc4;
    case (pcsource)
      PC_SEQ:  sel_tgt = pc4;
      PC_BR:   sel_tgt = bpc;
      PC_JR:   sel_tgt = da;
      PC_J:    sel_tgt = jpc;
      default: sel_tgt = pc4;
    endcase
  end

  assign redirect = (pcsource != PC_SEQ);
  assign npc      = pend ? pend_tgt : sel_tgt;

endmodule

// File: rtl/pipe_fetch.sv
// Instruction fetch plus IF/ID register with ready handshake and load-use stall.
// Define PIPE_FLUSH_EN to replace the branch delay slot with a one-cycle bubble.
module pipe_fetch
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  input  logic [31:0] da,
  input  logic        wpcir,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] dpc4,
  output logic [31:0] inst
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  dpc4_q, dpc4_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  pend_tgt_q, pend_tgt_d;

  logic [31:0]  pc4;
  logic [31:0]  sel_tgt;
  logic [31:0]  npc;
  logic         redirect;
  logic         pend;

  assign pc4  = pc_plus4(pc_q);
  assign pend = (state_q == PEND);

  pipe_npc u_npc (
    .pcsource (pcsource),
    .pc4      (pc4),
    .bpc      (bpc),
    .jpc      (jpc),
    .da       (da),
    .pend     (pend),
    .pend_tgt (pend_tgt_q),
    .sel_tgt  (sel_tgt),
    .redirect (redirect),
    .npc      (npc)
  );

`ifdef PIPE_FLUSH_EN
  logic taken;
  assign taken = pend || redirect;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    dpc4_d     = dpc4_q;
    inst_d     = inst_q;
    pend_tgt_d = pend_tgt_q;
    if (!wpcir) begin
      if (imem_ready) begin
        pc_d    = npc;
        state_d = RUN;
`ifdef PIPE_FLUSH_EN
        if (taken) begin
          inst_d = NOP_INST;
          dpc4_d = npc;
        end else begin
          inst_d = imem_rdata;
          dpc4_d = pc4;
        end
`else
        inst_d = imem_rdata;
        dpc4_d = pc4;
`endif
      end else begin
        inst_d = NOP_INST;
        // Only the first redirect seen while memory is busy is kept; later ones follow bubbles.
        if (!pend && redirect) begin
          pend_tgt_d = sel_tgt;
          state_d    = PEND;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      dpc4_q     <= 32'h0000_0000;
      inst_q     <= NOP_INST;
      pend_tgt_q <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      dpc4_q     <= dpc4_d;
      inst_q     <= inst_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  // The request follows reset directly so it drops in the same cycle reset is asserted.
  assign imem_req = resetn;
  assign pc       = pc_q;
  assign dpc4     = dpc4_q;
  assign inst     = inst_q;

endmodule
